seg_scan6: RTL

//  Six-digit multiplexed 7-segment display driver for the clock display (HH:MM:SS).

---
 rtl/seg_scan6_pkg.sv | 25 ++
 rtl/seg_scan6_bcd_to_seg7.sv | 30 +++
 rtl/seg_scan6.sv | 117 +++++++++++
 3 files changed

// File: rtl/seg_scan6_pkg.sv
// rtl/seg_scan6_pkg.sv - shared segment constants and idle values for the six-digit scanner
// Purpose: the seg7 patterns (active-high gfedcba), the dark/idle output values
//          and the digit count used by seg_scan6 and bcd_to_seg7.
// Ports:   none (package).
package seg_scan6_pkg;

    localparam int N_DIG = 6;

    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_DASH = 7'h40;

    // Common-anode display: all-high means every segment and every anode is off.
    localparam logic [7:0] SEG_OFF  = 8'hFF;
    localparam logic [5:0] AN_OFF   = 6'h3F;

endpackage

// File: rtl/seg_scan6_bcd_to_seg7.sv
// rtl/seg_scan6_bcd_to_seg7.sv - combinational BCD to 7-segment decoder
// Purpose: map a 4-bit BCD code to an active-high gfedcba pattern.
//          Codes 10..15 are not valid BCD and decode to a dash.
// Ports:   bcd (in, 4)  - BCD code
//          seg (out, 7) - active-high segment pattern {g,f,e,d,c,b,a}
module bcd_to_seg7
    import seg_scan6_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg_scan6.sv
// rtl/seg_scan6.sv - six-digit multiplexed common-anode 7-segment display driver
// Purpose: scans six BCD digits (HH:MM:SS) one slot at a time, with a dark
//          anti-ghost lead-in per slot, per-digit blink, per-digit DP and
//          dash marking of invalid codes. Outputs are registered (1-cycle latency).
// Ports:   CP    (in, 1)   clock, rising edge
//          nCLR  (in, 1)   asynchronous active-low reset
//          EN    (in, 1)   scan enable; low = dark display, counters hold
//          D     (in, 24)  BCD digits, D[3:0] = digit 0 ... D[23:20] = digit 5
//          BLINK (in, 6)   per-digit blink mask
//          DP    (in, 6)   per-digit decimal-point mask
//          SEG   (out, 8)  {dp,g,f,e,d,c,b,a}, active-low
//          AN    (out, 6)  digit select, active-low
module seg_scan6
    import seg_scan6_pkg::*;
#(
    parameter int SCAN_DIV     = 1000,
    parameter int BLANK_CYC    = 16,
    parameter int BLINK_FRAMES = 100
) (
    input  logic        CP,
    input  logic        nCLR,
    input  logic        EN,
    input  logic [23:0] D,
    input  logic [5:0]  BLINK,
    input  logic [5:0]  DP,
    output logic [7:0]  SEG,
    output logic [5:0]  AN
);

    localparam int PC_W = $clog2(SCAN_DIV);
    // A single-frame blink period still needs a one-bit counter that simply stays at 0.
    localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [PC_W-1:0] PC_LAST   = PC_W'(SCAN_DIV - 1);
    localparam logic [PC_W-1:0] BLANK_END = PC_W'(BLANK_CYC);
    localparam logic [FC_W-1:0] FC_LAST   = FC_W'(BLINK_FRAMES - 1);
    localparam logic [2:0]      IDX_LAST  = 3'(N_DIG - 1);

    logic [PC_W-1:0] pc_q,  pc_d;
    logic [2:0]      idx_q, idx_d;
    logic [FC_W-1:0] fc_q,  fc_d;
    logic            ph_q,  ph_d;
    logic [7:0]      seg_q, seg_d;
    logic [5:0]      an_q,  an_d;

    logic [3:0]      digit;
    logic [6:0]      digit_seg;

    assign digit = D[{idx_q, 2'b00} +: 4];

    bcd_to_seg7 u_dec (
        .bcd (digit),
        .seg (digit_seg)
    );

    // Counter chain: slot end carries into IDX, frame end carries into FC,
    // FC wrap toggles PH -- all on the same edge when they coincide.
    always_comb begin
        pc_d  = pc_q;
        idx_d = idx_q;
        fc_d  = fc_q;
        ph_d  = ph_q;
        if (EN) begin
            if (pc_q == PC_LAST) begin
                pc_d = '0;
                if (idx_q == IDX_LAST) begin
                    idx_d = '0;
                    if (fc_q == FC_LAST) begin
                        fc_d = '0;
                        ph_d = ~ph_q;
                    end else begin
                        fc_d = fc_q + 1'b1;
                    end
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end else begin
                pc_d = pc_q + 1'b1;
            end
        end
    end

    // Output mux: dark when disabled or in the blanking lead-in; during the
    // blink-off phase the anode still strobes so the scan timing stays uniform.
    always_comb begin
        seg_d = SEG_OFF;
        an_d  = AN_OFF;
        if (EN && (pc_q >= BLANK_END)) begin
            an_d = ~(6'b000001 << idx_q);
            if (!(ph_q && BLINK[idx_q])) begin
                seg_d = ~{DP[idx_q], digit_seg};
            end
        end
    end

    always_ff @(posedge CP or negedge nCLR) begin
        if (!nCLR) begin
            pc_q  <= '0;
            idx_q <= '0;
            fc_q  <= '0;
            ph_q  <= 1'b0;
            seg_q <= SEG_OFF;
            an_q  <= AN_OFF;
        end else begin
            pc_q  <= pc_d;
            idx_q <= idx_d;
            fc_q  <= fc_d;
            ph_q  <= ph_d;
            seg_q <= seg_d;
            an_q  <= an_d;
        end
    end

    assign SEG = seg_q;
    assign AN  = an_q;

endmodule
